uart_rx_deser_cfg: RTL and testbench

Configurable serial-to-parallel stage for the UART receive path. It sits between the data-sampling block, which supplies `sampled_bit` and the oversampling edge count, and the frame FSM, which supplies `enable` and `start`. Compared with the fixed 8-bit LSB-first deserializer it adds:
- runtime frame length, bit order and sample edge;
- a frame-complete strobe;
- a running parity result for the parity-check stage.

---
 rtl/uart_rx_deser_cfg.sv | 157 +++++++++++++++
 tb/tb_uart_rx_deser_cfg.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deser_cfg.sv
// -----------------------------------------------------------------------------
// uart_rx_deser_cfg
//
// Configurable serial-to-parallel stage of the UART receive path. Bits coming
// from the sampler are captured once per bit period (when edge_cnt reaches
// sample_edge while the frame FSM holds enable), placed LSB-first or MSB-first
// into the output word, and folded into a running parity result. A frame is
// armed by a start pulse, which also latches length, bit order and parity
// sense for the whole frame.
//
// Parameters:
//   DATA_WIDTH  maximum data bits per frame, width of P_DATA
//   EDGE_W      width of the oversampling edge counter
//   LEN_W       width of data_len; 2**LEN_W must exceed DATA_WIDTH
//
// Ports:
//   CLK          receive clock
//   RST          synchronous active-high reset
//   sampled_bit  majority-voted bit from the sampler
//   edge_cnt     current oversampling edge index within the bit
//   sample_edge  edge index at which the bit is captured
//   enable       frame FSM is in the data-bit state
//   start        one-cycle pulse at the start bit, arms a new frame
//   data_len     data bits per frame (0 or > DATA_WIDTH means DATA_WIDTH)
//   msb_first    0: LSB first, 1: MSB first
//   par_odd      0: even parity, 1: odd parity
//   P_DATA       assembled word, unused upper bits read 0
//   data_valid   one-cycle pulse when the last data bit has been stored
//   par_calc     expected parity bit for the bits received so far
//   busy         frame armed and not yet complete
// -----------------------------------------------------------------------------
module uart_rx_deser_cfg #(
   parameter int DATA_WIDTH = 8,
   parameter int EDGE_W     = 5,
   parameter int LEN_W      = 4
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  sampled_bit,
   input  logic [EDGE_W-1:0]     edge_cnt,
   input  logic [EDGE_W-1:0]     sample_edge,
   input  logic                  enable,
   input  logic                  start,
   input  logic [LEN_W-1:0]      data_len,
   input  logic                  msb_first,
   input  logic                  par_odd,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  data_valid,
   output logic                  par_calc,
   output logic                  busy
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(DATA_WIDTH);
   localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);

   state_t                state_reg, state_next;
   logic [LEN_W-1:0]      cnt_reg, cnt_next;
   logic [LEN_W-1:0]      len_reg, len_next;
   logic                  msb_reg, msb_next;
   logic                  odd_reg, odd_next;
   logic                  acc_reg, acc_next;
   logic                  pc_reg, pc_next;
   logic                  dv_reg, dv_next;
   logic [DATA_WIDTH-1:0] p_data_reg, p_data_next;

   logic [LEN_W-1:0]      eff_len;
   logic [LEN_W-1:0]      bit_idx;
   logic [DATA_WIDTH-1:0] captured_word;
   logic                  capture;
   logic                  last_bit;

   // Out-of-range lengths fall back to the full word width.
   assign eff_len = ((data_len == '0) || (data_len > FULL_LEN)) ? FULL_LEN : data_len;

   // start wins over a coincident capture, so the capture is masked here.
   assign capture  = (state_reg == ST_RUN) && enable && (edge_cnt == sample_edge) && !start;
   assign last_bit = (cnt_reg == (len_reg - ONE));

   // MSB-first frames fill the word from index L-1 downwards so the result
   // stays right-aligned regardless of the configured length.
   assign bit_idx = msb_reg ? (len_reg - ONE - cnt_reg) : cnt_reg;

   // Word as it looks after storing sampled_bit at bit_idx.
   for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_capture_bit
      assign captured_word[gi] = (bit_idx == LEN_W'(gi)) ? sampled_bit : p_data_reg[gi];
   end

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      len_next    = len_reg;
      msb_next    = msb_reg;
      odd_next    = odd_reg;
      acc_next    = acc_reg;
      p_data_next = p_data_reg;
      dv_next     = 1'b0;

      if (start) begin
         // Arming works from either state; in RUN it silently aborts the frame.
         state_next  = ST_RUN;
         cnt_next    = '0;
         acc_next    = 1'b0;
         len_next    = eff_len;
         msb_next    = msb_first;
         odd_next    = par_odd;
         p_data_next = '0;
      end else if (capture) begin
         p_data_next = captured_word;
         acc_next    = acc_reg ^ sampled_bit;
         if (last_bit) begin
            cnt_next   = '0;
            state_next = ST_IDLE;
            dv_next    = 1'b1;
         end else begin
            cnt_next = cnt_reg + ONE;
         end
      end

      // Holds in IDLE because acc and odd only move on start or capture.
      pc_next = acc_next ^ odd_next;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg  <= ST_IDLE;
         cnt_reg    <= '0;
         len_reg    <= FULL_LEN;
         msb_reg    <= 1'b0;
         odd_reg    <= 1'b0;
         acc_reg    <= 1'b0;
         pc_reg     <= 1'b0;
         dv_reg     <= 1'b0;
         p_data_reg <= '0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         len_reg    <= len_next;
         msb_reg    <= msb_next;
         odd_reg    <= odd_next;
         acc_reg    <= acc_next;
         pc_reg     <= pc_next;
         dv_reg     <= dv_next;
         p_data_reg <= p_data_next;
      end
   end

   assign P_DATA     = p_data_reg;
   assign data_valid = dv_reg;
   assign par_calc   = pc_reg;
   assign busy       = (state_reg == ST_RUN);

endmodule

// File: tb/tb_uart_rx_deser_cfg.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_deser_cfg
//
// Bench for uart_rx_deser_cfg. Edge counter is driven as a free-running
// modulo-8 count. A frame-level reference model tracks the expected word,
// parity and completion from the frame rules (placement by bit position,
// xor of received bits, completion after L captures).
// -----------------------------------------------------------------------------
module tb_uart_rx_deser_cfg;

   localparam int DW = 8;
   localparam int EW = 5;
   localparam int LW = 4;

   logic          CLK = 1'b0;
   logic          RST;
   logic          sampled_bit;
   logic [EW-1:0] edge_cnt;
   logic [EW-1:0] sample_edge;
   logic          enable;
   logic          start;
   logic [LW-1:0] data_len;
   logic          msb_first;
   logic          par_odd;
   logic [DW-1:0] P_DATA;
   logic          data_valid;
   logic          par_calc;
   logic          busy;

   int checks = 0;
   int errors = 0;
   int prescale = 8;

   // reference model state
   int            m_len;
   int            m_cnt;
   bit            m_msb, m_odd, m_busy, m_acc, m_pc, m_valid;
   logic [DW-1:0] m_word;

   uart_rx_deser_cfg #(.DATA_WIDTH(DW), .EDGE_W(EW), .LEN_W(LW)) dut (
      .CLK(CLK), .RST(RST), .sampled_bit(sampled_bit), .edge_cnt(edge_cnt),
      .sample_edge(sample_edge), .enable(enable), .start(start),
      .data_len(data_len), .msb_first(msb_first), .par_odd(par_odd),
      .P_DATA(P_DATA), .data_valid(data_valid), .par_calc(par_calc), .busy(busy)
   );

   always #5 CLK = ~CLK;

   // One clock; outputs are stable afterwards, and the edge counter advances.
   task automatic cyc();
      @(posedge CLK);
      #1;
      edge_cnt = EW'((int'(edge_cnt) + 1) % prescale);
   endtask

   task automatic model_reset();
      m_len = DW; m_cnt = 0; m_msb = 0; m_odd = 0; m_busy = 0;
      m_acc = 0; m_pc = 0; m_valid = 0; m_word = '0;
   endtask

   task automatic model_start(int len, bit msb, bit odd);
      m_len   = (len < 1 || len > DW) ? DW : len;
      m_msb   = msb;
      m_odd   = odd;
      m_word  = '0;
      m_acc   = 0;
      m_cnt   = 0;
      m_busy  = 1;
      m_pc    = odd;
      m_valid = 0;
   endtask

   task automatic model_capture(bit b);
      int pos;
      m_valid = 0;
      if (!m_busy) return;
      pos = m_msb ? (m_len - 1 - m_cnt) : m_cnt;
      m_word[pos] = b;
      m_acc = m_acc ^ b;
      m_pc  = m_acc ^ m_odd;
      m_cnt++;
      if (m_cnt == m_len) begin
         m_cnt   = 0;
         m_busy  = 0;
         m_valid = 1;
      end
   endtask

   // Start pulse; optionally coincident with a would-be capture of a 1.
   task automatic pulse_start(int len, bit msb, bit odd, bit coincide);
      enable = 1'b0;
      if (coincide) begin
         while (edge_cnt != sample_edge) cyc();
         enable      = 1'b1;
         sampled_bit = 1'b1;
      end
      start     = 1'b1;
      data_len  = LW'(len);
      msb_first = msb;
      par_odd   = odd;
      cyc();
      start = 1'b0;
      model_start(len, msb, odd);
      // mid-frame configuration changes must be ignored
      data_len  = LW'($urandom);
      msb_first = 1'($urandom);
      par_odd   = 1'($urandom);
   endtask

   // Drive one bit with enable held until the capture edge has been clocked.
   task automatic capture_bit(bit b, output int spurious);
      sampled_bit = b;
      enable      = 1'b1;
      spurious    = 0;
      while (edge_cnt != sample_edge) begin
         cyc();
         if (data_valid) spurious++;
      end
      cyc();
      model_capture(b);
   endtask

   task automatic test_reset();
      RST = 1'b1; start = 0; enable = 0; sampled_bit = 0; edge_cnt = '0;
      sample_edge = EW'(6); data_len = LW'(8); msb_first = 0; par_odd = 0;
      cyc(); cyc();
      model_reset();
      checks++;
      if (P_DATA !== '0 || data_valid !== 1'b0 || par_calc !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: P_DATA=%h dv=%b pc=%b busy=%b, required all 0",
                  P_DATA, data_valid, par_calc, busy);
      end
      RST = 1'b0;
      cyc();
      $display("reset done");
   endtask

   // Full frame; stream[i] is the i-th transmitted bit.
   task automatic test_frame(string name, logic [DW-1:0] stream, int len, bit msb, bit odd, bit coincide);
      int sp;
      pulse_start(len, msb, odd, coincide);
      checks++;
      if (busy !== 1'b1 || P_DATA !== '0 || data_valid !== 1'b0 || par_calc !== m_pc) begin
         errors++;
         $display("FAIL %s_arm: busy=%b P_DATA=%h dv=%b pc=%b, required busy=1 P_DATA=0 dv=0 pc=%b",
                  name, busy, P_DATA, data_valid, par_calc, m_pc);
      end
      for (int i = 0; i < m_len; i++) begin
         capture_bit(stream[i], sp);
         checks++;
         if (P_DATA !== m_word || par_calc !== m_pc || data_valid !== m_valid ||
             busy !== m_busy || sp != 0) begin
            errors++;
            $display("FAIL %s_bit%0d: P_DATA=%h pc=%b dv=%b busy=%b spurious=%0d, required %h %b %b %b 0",
                     name, i, P_DATA, par_calc, data_valid, busy, sp, m_word, m_pc, m_valid, m_busy);
         end
      end
      cyc();
      checks++;
      if (data_valid !== 1'b0 || P_DATA !== m_word || par_calc !== m_pc || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_hold: dv=%b P_DATA=%h pc=%b busy=%b, required 0 %h %b 0",
                  name, data_valid, P_DATA, par_calc, busy, m_word, m_pc);
      end
      $display("frame %s len=%0d msb=%0d odd=%0d word=%h par=%b", name, m_len, msb, odd, P_DATA, par_calc);
   endtask

   task automatic test_lsb();
      test_frame("lsb8", 8'h4D, 8, 0, 0, 0);
      checks++;
      if (P_DATA !== 8'h4D || par_calc !== 1'b0) begin
         errors++;
         $display("FAIL lsb8_value: P_DATA=%h pc=%b, required 4d 0", P_DATA, par_calc);
      end
   endtask

   task automatic test_msb();
      test_frame("msb8", 8'h4D, 8, 1, 0, 0);
      checks++;
      if (P_DATA !== 8'hB2 || par_calc !== 1'b0) begin
         errors++;
         $display("FAIL msb8_value: P_DATA=%h pc=%b, required b2 0", P_DATA, par_calc);
      end
      test_frame("msb8_odd", 8'h4D, 8, 1, 1, 0);
      checks++;
      if (P_DATA !== 8'hB2 || par_calc !== 1'b1) begin
         errors++;
         $display("FAIL msb8_odd_value: P_DATA=%h pc=%b, required b2 1", P_DATA, par_calc);
      end
   endtask

   task automatic test_short_len();
      int sp;
      test_frame("len5", 8'h1F, 5, 0, 0, 0);
      checks++;
      if (P_DATA !== 8'h1F || par_calc !== 1'b1) begin
         errors++;
         $display("FAIL len5_value: P_DATA=%h pc=%b, required 1f 1", P_DATA, par_calc);
      end
      capture_bit(1'b1, sp);
      checks++;
      if (P_DATA !== 8'h1F || data_valid !== 1'b0 || busy !== 1'b0 || sp != 0) begin
         errors++;
         $display("FAIL len5_idle_capture: P_DATA=%h dv=%b busy=%b, required 1f 0 0",
                  P_DATA, data_valid, busy);
      end
      $display("idle capture P_DATA=%h", P_DATA);
   endtask

   task automatic test_len_clamp();
      test_frame("len0", 8'($urandom), 0, 0, 0, 0);
      test_frame("len12", 8'($urandom), 12, 1, 1, 0);
   endtask

   task automatic test_abort();
      int sp;
      pulse_start(8, 0, 0, 0);
      for (int i = 0; i < 3; i++) capture_bit(1'b1, sp);
      checks++;
      if (P_DATA !== 8'h07 || busy !== 1'b1) begin
         errors++;
         $display("FAIL abort_partial: P_DATA=%h busy=%b, required 07 1", P_DATA, busy);
      end
      // the re-arming start inside test_frame aborts the partial frame
      test_frame("after_abort", 8'hA5, 8, 0, 0, 0);
      checks++;
      if (P_DATA !== 8'hA5) begin
         errors++;
         $display("FAIL abort_value: P_DATA=%h, required a5", P_DATA);
      end
   endtask

   task automatic test_start_capture();
      test_frame("start_cap", 8'h5A, 8, 0, 0, 1);
      checks++;
      if (P_DATA !== 8'h5A) begin
         errors++;
         $display("FAIL start_cap_value: P_DATA=%h, required 5a", P_DATA);
      end
   endtask

   task automatic test_reset_mid();
      int sp;
      pulse_start(8, 0, 1, 0);
      for (int i = 0; i < 4; i++) capture_bit(1'b1, sp);
      RST = 1'b1;
      cyc();
      model_reset();
      checks++;
      if (P_DATA !== '0 || data_valid !== 1'b0 || par_calc !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: P_DATA=%h dv=%b pc=%b busy=%b, required all 0",
                  P_DATA, data_valid, par_calc, busy);
      end
      RST = 1'b0;
      for (int i = 0; i < 12; i++) begin
         cyc();
         if (data_valid !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL reset_mid_dv: dv=%b, required 0", data_valid);
         end
      end
      test_frame("after_reset", 8'h3C, 8, 0, 0, 0);
      checks++;
      if (P_DATA !== 8'h3C) begin
         errors++;
         $display("FAIL reset_value: P_DATA=%h, required 3c", P_DATA);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 20; n++) begin
         sample_edge = EW'($urandom_range(0, 7));
         test_frame("rand", 8'($urandom), int'($urandom_range(0, 15)),
                    1'($urandom), 1'($urandom), 1'($urandom));
      end
   endtask

   initial begin
      test_reset();
      test_lsb();
      test_msb();
      test_short_len();
      test_len_clamp();
      test_abort();
      test_start_capture();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // absolute time bound in case a wait never resolves
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete, required completion");
      $fatal(1, "timeout");
   end

endmodule
